// File: rtl/temporal_encoder.sv
// Binary-to-temporal encoder: latches N values, then drops line i from high to low
// at gamma time val_q[i] inside a 2**W-cycle window, followed by a rest phase.
module temporal_encoder #(
  parameter int N           = 4,
  parameter int W           = 3,
  parameter int REST_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_vals,
  output logic [N-1:0]   spike_out,
  output logic [W-1:0]   time_out,
  output logic           busy,
  output logic           done
);

  // Handshake: a value set transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE and never depends combinationally on in_valid.

  localparam int RW = $clog2(REST_CYCLES + 1);
  localparam logic [W-1:0]  CNT_MAX   = '1;
  localparam logic [RW-1:0] REST_LAST = RW'(REST_CYCLES - 1);
  localparam logic [W-1:0]  NO_SPIKE  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REST = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [W-1:0]    cnt;
  logic [RW-1:0]   rest_cnt;
  logic [N*W-1:0]  val_q;
  logic            accept;

  assign accept = in_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt == CNT_MAX) state_d = REST;
      REST:    if (rest_cnt == REST_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters saturate at their phase end so they never wrap inside a phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      rest_cnt <= '0;
      val_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            val_q <= in_vals;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (cnt == CNT_MAX) rest_cnt <= '0;
          else                cnt      <= cnt + 1'b1;
        end
        REST: begin
          if (rest_cnt != REST_LAST) rest_cnt <= rest_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line decode uses registered state only; an all-ones value never fires.
  always_comb begin
    spike_out = '1;
    for (int i = 0; i < N; i++) begin
      if ((state_q == RUN) && (cnt >= val_q[i*W +: W]) && (val_q[i*W +: W] != NO_SPIKE))
        spike_out[i] = 1'b0;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == REST) && (rest_cnt == REST_LAST);
  assign time_out = (state_q == RUN) ? cnt : '0;

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder (N=4, W=3, REST_CYCLES=2): checks reset,
// spike timing per window, ignored mid-window input, mid-run reset, back-to-back.
module tb_temporal_encoder;

  localparam int N = 4;
  localparam int W = 3;
  localparam int REST_CYCLES = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_vals;
  logic [N-1:0]   spike_out;
  logic [W-1:0]   time_out;
  logic           busy;
  logic           done;

  int vectors    = 0;
  int miscompares = 0;

  temporal_encoder #(.N(N), .W(W), .REST_CYCLES(REST_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vals   (in_vals),
    .spike_out (spike_out),
    .time_out  (time_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle, so checks happen away from the clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a value set at an IDLE cycle and take edge E0.
  task automatic accept(input string tag, input logic [N*W-1:0] vals, input bit keep_valid);
    in_valid = 1'b1;
    in_vals  = vals;
    chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    tick();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Check cycles 1..10 after E0 and the first IDLE cycle 11.
  // pulse_k >= 1 drives a stray in_valid with {1,1,1,1} during that cycle.
  task automatic check_window(input string tag, input logic [9:0][3:0] exp_sp, input int pulse_k);
    for (int k = 0; k < 10; k++) begin
      if (pulse_k == k + 1) begin
        in_valid = 1'b1;
        in_vals  = 12'h249;
      end else if (pulse_k == k) begin
        in_valid = 1'b0;
      end
      chk($sformatf("%s_spike_c%0d", tag, k + 1), 32'(spike_out), 32'(exp_sp[k]));
      chk($sformatf("%s_time_c%0d", tag, k + 1), 32'(time_out), (k < 8) ? 32'(k) : 32'd0);
      chk($sformatf("%s_busy_c%0d", tag, k + 1), 32'(busy), 32'd1);
      chk($sformatf("%s_done_c%0d", tag, k + 1), 32'(done), (k == 9) ? 32'd1 : 32'd0);
      chk($sformatf("%s_ready_c%0d", tag, k + 1), 32'(in_ready), 32'd0);
      tick();
    end
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_spike"}, 32'(spike_out), 32'hF);
    chk({tag, "_idle_time"}, 32'(time_out), 32'd0);
  endtask

  // Expected spike_out per cycle, listed cycle 10 down to cycle 1.
  localparam logic [9:0][3:0] SP_7530 = {4'hF, 4'hF, 4'h8, 4'h8, 4'h8, 4'hC, 4'hC, 4'hE, 4'hE, 4'hE};
  localparam logic [9:0][3:0] SP_2222 = {4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
  localparam logic [9:0][3:0] SP_0123 = {4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_vals  = '0;

    // Reset held for two edges.
    tick();
    tick();
    chk("rst_spike", 32'(spike_out), 32'hF);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_time", 32'(time_out), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_spike", 32'(spike_out), 32'hF);

    // {7,5,3,0}: line0 c1, line1 c4, line2 c6, line3 never.
    accept("w7530", {3'd7, 3'd5, 3'd3, 3'd0}, 1'b0);
    check_window("w7530", SP_7530, 0);

    // {2,2,2,2}: all lines fall together in cycle 3.
    accept("w2222", {3'd2, 3'd2, 3'd2, 3'd2}, 1'b0);
    check_window("w2222", SP_2222, 0);

    // Stray in_valid with {1,1,1,1} in cycle 3 must not disturb the window.
    accept("wpulse", {3'd7, 3'd5, 3'd3, 3'd0}, 1'b0);
    check_window("wpulse", SP_7530, 3);
    in_vals = '0;

    // Reset at RUN cnt=4 (cycle 5): back to IDLE, no done pulse.
    accept("wrst", {3'd7, 3'd5, 3'd3, 3'd0}, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk("wrst_time_before", 32'(time_out), 32'd4);
    chk("wrst_spike_before", 32'(spike_out), 32'hC);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("wrst_spike", 32'(spike_out), 32'hF);
    chk("wrst_ready", 32'(in_ready), 32'd1);
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_time", 32'(time_out), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wrst_nodone_%0d", k), 32'(done), 32'd0);
      chk($sformatf("wrst_staybusy0_%0d", k), 32'(busy), 32'd0);
      tick();
    end
    accept("wfresh", {3'd7, 3'd5, 3'd3, 3'd0}, 1'b0);
    check_window("wfresh", SP_7530, 0);

    // in_valid held high with {0,1,2,3}: accept every 11 cycles.
    for (int r = 0; r < 3; r++) begin
      accept($sformatf("b2b%0d", r), {3'd0, 3'd1, 3'd2, 3'd3}, 1'b1);
      check_window($sformatf("b2b%0d", r), SP_0123, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("final_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
